// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side consumer for a FIFO read port (fifo_rd_en / fifo_rdata / fifo_empty).
// A start command pulls exactly `len` words from the FIFO. The FIFO's one-cycle
// read latency is absorbed in a 2-entry output buffer. The words are then
// presented downstream as a valid/ready stream with a last marker. Completion,
// the number of words delivered, and an empty-timeout abort are also reported.
//
// Ports
//   rd_clk       single clock, all logic on posedge
//   res          asynchronous, active-high reset
//   start, len   burst request and length, sampled only while idle
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
//   err_timeout  one-cycle pulse, coincident with done when a burst aborts
//   rd_count     words accepted downstream in the current/last burst
//   fifo_rd_en   FIFO read strobe (combinational)
//   fifo_rdata   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   FIFO empty flag
//   m_valid, m_data, m_last, m_ready   output stream
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low, m_valid
// stays high and m_data/m_last stay stable. m_valid never depends on m_ready.
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             rd_clk,
  input  logic             res,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [LEN_W-1:0] rd_count,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  // The empty-cycle counter only has to reach TIMEOUT-1. The expiring cycle
  // is detected combinationally, so the counter never holds TIMEOUT itself.
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] reads_left_q, reads_left_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic [LEN_W-1:0] rd_count_q, rd_count_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;   // head entry, drives m_data
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             pop;
  logic             push;
  logic             rd_en;
  logic [2:0]       level;
  logic             empty_wait;
  logic             to_expire;

  // ---------------------------------------------------------------------------
  // Read issue and timeout detection
  // ---------------------------------------------------------------------------
  always_comb begin
    pop   = (occ_q != 2'd0) && m_ready;
    push  = inflight_q;
    level = {1'b0, occ_q} + {2'b00, inflight_q};
    // (occ + inflight - pop) < 2, rearranged so no subtraction can underflow.
    // This also guarantees that a captured word always has a free buffer slot.
    rd_en = (state_q == ST_RUN) && !fifo_empty && (reads_left_q != '0) &&
            (level < (3'd2 + {2'b00, pop}));
    empty_wait = (state_q == ST_RUN) && (reads_left_q != '0) && fifo_empty;
    to_expire  = empty_wait && (to_cnt_q == TO_LAST);
  end

  // ---------------------------------------------------------------------------
  // Next state: FSM, counters, and 2-entry buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    reads_left_d = reads_left_q;
    words_left_d = words_left_q;
    rd_count_d   = rd_count_q;
    to_cnt_d     = to_cnt_q;
    inflight_d   = rd_en;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    // Buffer: the capture writes the tail and the pop advances the head.
    // When a capture and a pop happen together, occ stays unchanged.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rdata;
        else               buf1_d = fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rdata;
        end
      end
      default: ;
    endcase

    if (pop) begin
      rd_count_d   = rd_count_q + LEN_W'(1);
      words_left_d = words_left_q - LEN_W'(1);
    end

    if (rd_en) reads_left_d = reads_left_q - LEN_W'(1);

    // The timeout counter counts consecutive starved cycles only.
    if (empty_wait) to_cnt_d = to_cnt_q + TO_W'(1);
    else            to_cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          reads_left_d = len;
          words_left_d = len;
          rd_count_d   = '0;
          to_cnt_d     = '0;
          if (len == '0) done_d  = 1'b1;
          else           state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (to_expire) begin
          // Abort: drop buffered and in-flight words. A pop in this same
          // cycle was already accepted downstream, so it still counts.
          state_d    = ST_IDLE;
          occ_d      = 2'd0;
          inflight_d = 1'b0;
          buf0_d     = '0;
          buf1_d     = '0;
          to_cnt_d   = '0;
          done_d     = 1'b1;
          err_d      = 1'b1;
        end else if (rd_en && (reads_left_q == LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (words_left_q == LEN_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      state_q      <= ST_IDLE;
      reads_left_q <= '0;
      words_left_q <= '0;
      rd_count_q   <= '0;
      to_cnt_q     <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      reads_left_q <= reads_left_d;
      words_left_q <= words_left_d;
      rd_count_q   <= rd_count_d;
      to_cnt_q     <= to_cnt_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    err_timeout = err_q;
    rd_count    = rd_count_q;
    fifo_rd_en  = rd_en;
    m_valid     = (occ_q != 2'd0);
    m_data      = buf0_q;
    m_last      = (occ_q != 2'd0) && (words_left_q == LEN_W'(1));
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer for the team's FIFO read port (rd_en / rdata / empty). On a start command it pulls exactly `len` words from the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents them as a valid/ready stream with a last marker. It sits in the read clock domain and replaces ad-hoc rd_en pulsing in downstream logic. It also reports completion, words delivered, and an empty-timeout abort.

## Interface
- WIDTH, 8, FIFO data width
- LEN_W, 8, burst length / counter width
- TIMEOUT, 16, consecutive empty cycles that abort a burst (≥1)
- rd_clk  in  1  single clock, all logic posedge
- res  in  1  reset, asynchronous, active-high
- start  in  1  burst request, sampled only in IDLE
- len  in  LEN_W  words to read, sampled with start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err_timeout  out  1  one-cycle pulse, coincident with done on abort
- rd_count  out  LEN_W  words accepted downstream in current/last burst
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rdata  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- m_valid  out  1  stream data valid
- m_data  out  WIDTH  stream data
- m_last  out  1  final word of burst, qualified by m_valid
- m_ready  in  1  downstream accept

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches len into reads_left and words_left, clears rd_count, goes to RUN (len=0: goes straight back to IDLE with done=1 next cycle, no reads). start ignored outside IDLE.
- fifo_rd_en (combinational) = RUN && !fifo_empty && reads_left≠0 && (occ + inflight − pop) < 2; occ = buffer entries (0..2), inflight = rd_en registered last cycle, pop = m_valid && m_ready.
- Never asserts fifo_rd_en while fifo_empty=1; the FIFO's underflow must never set due to this block.
- Each fifo_rd_en decrements reads_left; when reads_left reaches 0 → DRAIN.
- inflight=1: fifo_rdata written into buffer tail that edge.
- Buffer is 2-entry FIFO; m_data/m_valid driven from head register.
- pop: increments rd_count, decrements words_left. m_last = m_valid && words_left==1.
- DRAIN: when pop with words_left==1 → IDLE, done=1 next cycle, busy=0.
- Timeout: in RUN, counter counts cycles with reads_left≠0 && fifo_empty=1; reset to 0 on any non-empty cycle. Reaching TIMEOUT → IDLE; buffer and inflight word discarded, m_valid=0; done=1 and err_timeout=1 next cycle. rd_count holds accepted count.
- Simultaneous pop and capture: legal; occ unchanged.
- m_data stable and m_valid held while m_valid && !m_ready.

## Timing
- Reset (async, any time): state IDLE; busy, done, err_timeout, fifo_rd_en, m_valid, m_last = 0; m_data = 0; rd_count = 0; buffer, counters cleared; in-flight words lost. Reset mid-burst gives no done.
- start at edge T0 → busy=1 and earliest fifo_rd_en in cycle T0+1 → data captured at edge ending T0+2 → m_valid=1 in cycle T0+3.
- Steady state with FIFO non-empty and m_ready=1: one word per cycle.
- m_ready low: at most 2 reads outstanding (occ+inflight ≤ 2); fifo_rd_en drops until pop.
- done is a single-cycle pulse the cycle after last pop; busy falls same cycle; new start accepted in that cycle.
- rd_count wraps modulo 2^LEN_W only if len=2^LEN_W−1 is exceeded (cannot occur).

## Test plan
- FIFO preloaded with 0x11..0x14, start len=4, m_ready=1 → fifo_rd_en 4 consecutive cycles, m_data 0x11,0x12,0x13,0x14 on consecutive cycles, m_last on 0x14, done next cycle, rd_count=4, FIFO underflow never set.
- Same load, m_ready toggling 1/0 each cycle → no word lost/duplicated, occ+inflight never >2, fifo_rd_en never high with fifo_empty=1.
- start len=0 → no fifo_rd_en, done=1 one cycle after start, err_timeout=0, rd_count=0.
- FIFO holds 2 words, start len=5, TIMEOUT=16 → 2 words delivered without m_last, 16 empty cycles later done=1 and err_timeout=1 together, rd_count=2.
- Writer trickles 1 word every 5 cycles, len=3 → burst completes without timeout, m_last on third word.
- res asserted mid-burst (after 2 pops of len=6) → all outputs 0 immediately, no done; subsequent start len=1 works normally.
